serial_adder: RTL and testbench

Bit-serial N-bit adder built around the gate-level `full_adder` cell: one `full_adder` instance plus a carry flip-flop, processing one bit pair per clock, LSB first. It consumes the `full_adder` outputs each cycle and feeds a registered multi-bit result downstream. It trades latency (N cycles) for area, and serves as the sequential counterpart to the combinational ripple stage.

---
 rtl/serial_adder.sv | 143 ++++++++++++++
 tb/tb_serial_adder.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// Bit-serial N_BITS adder: one gate-level full_adder plus a carry flop, one bit per clock, LSB first.
// Optional two's-complement overflow output enabled by defining SERIAL_ADDER_OVERFLOW_EN.

module full_adder (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic s_o,
    output logic co_o
);
    logic axb;

    assign axb  = a_i ^ b_i;
    assign s_o  = axb ^ c_i;
    assign co_o = (a_i & b_i) | (c_i & axb);
endmodule

module serial_adder #(
    parameter int N_BITS = 8
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic [N_BITS-1:0] i_a,
    input  logic [N_BITS-1:0] i_b,
    input  logic              i_carry_in,
    output logic              o_busy,
    output logic              o_done,
    output logic [N_BITS-1:0] o_s,
    output logic              o_carry_out
`ifdef SERIAL_ADDER_OVERFLOW_EN
    ,
    output logic              o_overflow
`endif
);
    localparam int CW = $clog2(N_BITS) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [N_BITS-1:0] a_sh_q, a_sh_d;
    logic [N_BITS-1:0] b_sh_q, b_sh_d;
    // Only N_BITS-1 bits need storing: the final bit is merged straight into the result.
    logic [N_BITS-2:0] sum_sh_q, sum_sh_d;
    logic              carry_q, carry_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [N_BITS-1:0] s_q, s_d;
    logic              cout_q, cout_d;
    logic              ovf_q, ovf_d;

    logic              fa_s, fa_co;
    logic [N_BITS-1:0] sum_cat;

    full_adder u_fa (
        .a_i  (a_sh_q[0]),
        .b_i  (b_sh_q[0]),
        .c_i  (carry_q),
        .s_o  (fa_s),
        .co_o (fa_co)
    );

    assign sum_cat = {fa_s, sum_sh_q};

    always_comb begin
        state_d  = state_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        sum_sh_d = sum_sh_q;
        carry_d  = carry_q;
        cnt_d    = cnt_q;
        s_d      = s_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;
        unique case (state_q)
            IDLE: begin
                if (i_start) begin
                    a_sh_d  = i_a;
                    b_sh_d  = i_b;
                    carry_d = i_carry_in;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                a_sh_d   = a_sh_q >> 1;
                b_sh_d   = b_sh_q >> 1;
                sum_sh_d = sum_cat[N_BITS-1:1];
                carry_d  = fa_co;
                if (cnt_q == CW'(N_BITS - 1)) begin
                    // carry_q is the carry into the MSB, fa_co the carry out of it
                    s_d     = sum_cat;
                    cout_d  = fa_co;
                    ovf_d   = carry_q ^ fa_co;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= IDLE;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            sum_sh_q <= '0;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
            s_q      <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            sum_sh_q <= sum_sh_d;
            carry_q  <= carry_d;
            cnt_q    <= cnt_d;
            s_q      <= s_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
        end
    end

    assign o_busy      = (state_q == RUN);
    assign o_done      = (state_q == DONE);
    assign o_s         = s_q;
    assign o_carry_out = cout_q;

`ifdef SERIAL_ADDER_OVERFLOW_EN
    assign o_overflow = ovf_q;
`else
    logic unused_ovf;
    assign unused_ovf = ovf_q;
`endif
endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder (N_BITS=8); expected sums are hand-computed.
`timescale 1ns/1ps
module tb_serial_adder;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] a = '0;
    logic [7:0] b = '0;
    logic       cin = 1'b0;
    logic       busy, done, cout;
    logic [7:0] s;
`ifdef SERIAL_ADDER_OVERFLOW_EN
    logic       ovf;
`endif
    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    serial_adder #(.N_BITS(8)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_start     (start),
        .i_a         (a),
        .i_b         (b),
        .i_carry_in  (cin),
        .o_busy      (busy),
        .o_done      (done),
        .o_s         (s),
        .o_carry_out (cout)
`ifdef SERIAL_ADDER_OVERFLOW_EN
        ,
        .o_overflow  (ovf)
`endif
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Launch one add, then follow it to its o_done sample point.
    task automatic run_op(input logic [7:0] ta, input logic [7:0] tb, input logic tc,
                          input logic [7:0] es, input logic ec, input string tag);
        logic [7:0] s0;
        int bc, lat;
        bit stable, both;
        s0 = s; stable = 1; both = 0; bc = 0; lat = 0;
        a = ta; b = tb; cin = tc; start = 1'b1;
        tick;
        start = 1'b0;
        a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
        if (busy) bc++;
        if (busy && done) both = 1;
        if (s !== s0) stable = 0;
        for (int i = 1; i <= 20; i++) begin
            tick;
            if (busy && done) both = 1;
            if (done) begin
                lat = i;
                break;
            end
            if (busy) bc++;
            if (s !== s0) stable = 0;
        end
        chk({tag, " latency"}, lat, 8);
        chk({tag, " busy_cycles"}, bc, 8);
        chk({tag, " s_stable"}, 32'(stable), 1);
        chk({tag, " busy_and_done"}, 32'(both), 0);
        chk({tag, " sum"}, s, es);
        chk({tag, " carry"}, cout, ec);
    endtask

    initial begin
        int ndone;
        bit busy_seen;
        rst = 1'b1;
        tick; tick;
        rst = 1'b0;
        chk("reset busy", busy, 0);
        chk("reset done", done, 0);
        chk("reset sum", s, 0);
        chk("reset carry", cout, 0);
`ifdef SERIAL_ADDER_OVERFLOW_EN
        chk("reset ovf", ovf, 0);
`endif
        tick;

        run_op(8'h00, 8'h00, 1'b0, 8'h00, 1'b0, "zero");
        tick;
        run_op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, "ff+01");
        tick;
        run_op(8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1, "a5+5a+1");
        tick;

        // start pulses during RUN and DONE must be ignored
        a = 8'h12; b = 8'h34; cin = 1'b0; start = 1'b1;
        tick;
        start = 1'b0;
        tick; tick;
        a = 8'hFF; b = 8'hFF; start = 1'b1;
        tick;
        start = 1'b0;
        ndone = 0;
        for (int i = 0; i < 20 && ndone == 0; i++) begin
            tick;
            if (done) ndone++;
        end
        chk("ign done_seen", ndone, 1);
        a = 8'hFF; b = 8'hFF; start = 1'b1;
        tick;
        start = 1'b0;
        busy_seen = 0;
        for (int i = 0; i < 12; i++) begin
            if (busy) busy_seen = 1;
            if (done) ndone++;
            tick;
        end
        chk("ign done_count", ndone, 1);
        chk("ign busy_after", 32'(busy_seen), 0);
        chk("ign sum", s, 8'h46);
        chk("ign carry", cout, 0);

        // reset in the middle of RUN
        a = 8'hF0; b = 8'h0F; cin = 1'b0; start = 1'b1;
        tick;
        start = 1'b0;
        tick; tick; tick;
        chk("midrst busy_before", busy, 1);
        rst = 1'b1;
        tick;
        rst = 1'b0;
        chk("midrst busy", busy, 0);
        chk("midrst done", done, 0);
        chk("midrst sum", s, 0);
        chk("midrst carry", cout, 0);
        tick;
        run_op(8'h03, 8'h04, 1'b0, 8'h07, 1'b0, "after_rst");
        tick;

        // back-to-back: second start in the first IDLE cycle after o_done
        run_op(8'h3C, 8'h4B, 1'b1, 8'h88, 1'b0, "b2b_1");
        tick;
        run_op(8'hC8, 8'h9D, 1'b0, 8'h65, 1'b1, "b2b_2");
        tick;

`ifdef SERIAL_ADDER_OVERFLOW_EN
        run_op(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, "ovf 7f+01");
        chk("ovf 7f+01 flag", ovf, 1);
        tick;
        run_op(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, "ovf 80+80");
        chk("ovf 80+80 flag", ovf, 1);
        tick;
        run_op(8'h40, 8'h10, 1'b0, 8'h50, 1'b0, "ovf 40+10");
        chk("ovf 40+10 flag", ovf, 0);
        tick;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
